// File: rtl/dac_readback_fsm.sv
// dac_readback_fsm
// Answers the UART read-back command "v". It reads two bytes from the DAC
// over I2C, then replies "V" followed by ten ASCII '0'/'1' characters (DAC
// code bits [11:2], MSB first) and LF. If the I2C read does not complete in
// time, it replies "E" LF instead.
//
// Handshake rules:
//   - UART_DataReady and I2CDataReady are single-cycle strobes. Their data
//     is sampled only in that cycle.
//   - I2C_load and UART_TxLoad are registered single-cycle strobes. Each is
//     issued only after the matching busy input was seen low in the
//     previous cycle.
//   - After a UART_TxLoad the transmitter raises UART_TxBusy one cycle
//     late. TX_WAIT therefore ignores busy in its first cycle.
module dac_readback_fsm #(
  parameter logic [6:0] DAC_ADDR       = 7'b0001101,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  UART_Rx,
  input  logic        UART_DataReady,
  output logic [7:0]  UART_Tx,
  output logic        UART_TxLoad,
  input  logic        UART_TxBusy,
  output logic [6:0]  I2Caddr,
  output logic        I2Cr_w,
  output logic        I2Cbytes,
  output logic        I2C_load,
  input  logic        I2CBusy,
  input  logic        I2CDataReady,
  input  logic [15:0] I2CRxData,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_I2C_REQ  = 3'd1,
    S_I2C_WAIT = 3'd2,
    S_TX_LOAD  = 3'd3,
    S_TX_WAIT  = 3'd4,
    S_TX_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]      CMD_READ = 8'h76;  // "v"
  localparam logic [7:0]      CH_V     = 8'h56;  // "V"
  localparam logic [7:0]      CH_E     = 8'h45;  // "E"
  localparam logic [7:0]      CH_LF    = 8'h0A;
  localparam logic [7:0]      CH_0     = 8'h30;
  localparam logic [7:0]      CH_1     = 8'h31;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [15:0]       r_data;
  logic [3:0]        r_idx;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_err;
  logic              r_first;
  logic [7:0]        r_tx;
  logic              r_tx_load;
  logic              r_i2c_load;

  state_t            w_state_nx;
  logic [15:0]       w_data_nx;
  logic [3:0]        w_idx_nx;
  logic [TO_W-1:0]   w_to_nx;
  logic              w_err_nx;
  logic              w_first_nx;
  logic [7:0]        w_tx_nx;
  logic              w_tx_load_nx;
  logic              w_i2c_load_nx;

  logic [3:0]        w_last_idx;
  logic [3:0]        w_bit_sel;
  logic [7:0]        w_byte;

  // The I2C request parameters are fixed: a 2-byte read from the DAC.
  assign I2Caddr     = DAC_ADDR;
  assign I2Cr_w      = 1'b1;
  assign I2Cbytes    = 1'b1;
  assign UART_Tx     = r_tx;
  assign UART_TxLoad = r_tx_load;
  assign I2C_load    = r_i2c_load;
  assign o_dbg_state = r_state;

  // Select the reply byte for the current index. Index 1 maps to data bit 11
  // and index 10 maps to data bit 2.
  always_comb begin
    w_last_idx = r_err ? 4'd1 : 4'd11;
    w_bit_sel  = 4'd12 - r_idx;
    w_byte     = CH_LF;
    if (r_err) begin
      w_byte = (r_idx == 4'd0) ? CH_E : CH_LF;
    end else if (r_idx == 4'd0) begin
      w_byte = CH_V;
    end else if (r_idx == 4'd11) begin
      w_byte = CH_LF;
    end else begin
      w_byte = r_data[w_bit_sel] ? CH_1 : CH_0;
    end
  end

  // Compute the next state and the next value of every register.
  always_comb begin
    w_state_nx    = r_state;
    w_data_nx     = r_data;
    w_idx_nx      = r_idx;
    w_to_nx       = r_to_cnt;
    w_err_nx      = r_err;
    w_first_nx    = r_first;
    w_tx_nx       = r_tx;
    w_tx_load_nx  = 1'b0;
    w_i2c_load_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (UART_DataReady && (UART_Rx == CMD_READ)) begin
          w_state_nx = S_I2C_REQ;
        end
      end
      S_I2C_REQ: begin
        if (!I2CBusy) begin
          w_i2c_load_nx = 1'b1;
          w_to_nx       = '0;
          w_state_nx    = S_I2C_WAIT;
        end
      end
      S_I2C_WAIT: begin
        w_to_nx = r_to_cnt + TO_W'(1);
        // If data and timeout arrive in the same cycle, the data wins.
        if (I2CDataReady) begin
          w_data_nx  = I2CRxData;
          w_err_nx   = 1'b0;
          w_idx_nx   = 4'd0;
          w_state_nx = S_TX_LOAD;
        end else if (r_to_cnt == TO_LAST) begin
          w_err_nx   = 1'b1;
          w_idx_nx   = 4'd0;
          w_state_nx = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (!UART_TxBusy) begin
          w_tx_nx      = w_byte;
          w_tx_load_nx = 1'b1;
          w_first_nx   = 1'b1;
          w_state_nx   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (r_first) begin
          w_first_nx = 1'b0;
        end else if (!UART_TxBusy) begin
          if (r_idx == w_last_idx) begin
            w_state_nx = S_TX_DONE;
          end else begin
            w_idx_nx   = r_idx + 4'd1;
            w_state_nx = S_TX_LOAD;
          end
        end
      end
      S_TX_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_idx      <= '0;
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
      r_first    <= 1'b0;
      r_tx       <= 8'h00;
      r_tx_load  <= 1'b0;
      r_i2c_load <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_data     <= w_data_nx;
      r_idx      <= w_idx_nx;
      r_to_cnt   <= w_to_nx;
      r_err      <= w_err_nx;
      r_first    <= w_first_nx;
      r_tx       <= w_tx_nx;
      r_tx_load  <= w_tx_load_nx;
      r_i2c_load <= w_i2c_load_nx;
    end
  end

endmodule

// File: tb/tb_dac_readback_fsm.sv
// Testbench for dac_readback_fsm. The timeout is shortened to 16 cycles.
module tb_dac_readback_fsm;

  logic        clk;
  logic        rst;
  logic [7:0]  uart_rx;
  logic        uart_data_ready;
  logic [7:0]  uart_tx;
  logic        uart_tx_load;
  logic        uart_tx_busy;
  logic [6:0]  i2c_addr;
  logic        i2c_r_w;
  logic        i2c_bytes;
  logic        i2c_load;
  logic        i2c_busy;
  logic        i2c_data_ready;
  logic [15:0] i2c_rx_data;
  logic [2:0]  dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;
  int i2c_load_cnt = 0;
  int busy_viol = 0;
  int busy_len = 1;
  int busy_cnt = 0;
  logic busy_pend = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  dac_readback_fsm #(
    .DAC_ADDR(7'b0001101),
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .UART_Rx(uart_rx),
    .UART_DataReady(uart_data_ready),
    .UART_Tx(uart_tx),
    .UART_TxLoad(uart_tx_load),
    .UART_TxBusy(uart_tx_busy),
    .I2Caddr(i2c_addr),
    .I2Cr_w(i2c_r_w),
    .I2Cbytes(i2c_bytes),
    .I2C_load(i2c_load),
    .I2CBusy(i2c_busy),
    .I2CDataReady(i2c_data_ready),
    .I2CRxData(i2c_rx_data),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor + UART transmitter model ----------------
  // Busy rises one cycle after a load and stays high for busy_len cycles.
  always @(negedge clk) begin
    if (uart_tx_load) begin
      if (uart_tx_busy) busy_viol = busy_viol + 1;
      got_q.push_back(uart_tx);
    end
    if (i2c_load) i2c_load_cnt = i2c_load_cnt + 1;
    if (busy_pend) begin
      busy_cnt  = busy_len;
      busy_pend = 1'b0;
    end
    if (uart_tx_load) busy_pend = 1'b1;
    uart_tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (act !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = b;
    uart_data_ready = 1'b1;
    @(negedge clk);
    uart_data_ready = 1'b0;
  endtask

  // Waits for the I2C_load strobe. Returns the number of negedges waited,
  // or -1 on timeout.
  task automatic wait_i2c_load(output int n);
    n = 0;
    while (!i2c_load && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!i2c_load) n = -1;
  endtask

  task automatic i2c_respond(input int delay, input logic [15:0] d);
    tick(delay);
    i2c_rx_data = d;
    i2c_data_ready = 1'b1;
    @(negedge clk);
    i2c_data_ready = 1'b0;
  endtask

  // Waits until n bytes have been seen and the FSM is idle again.
  task automatic wait_reply(input string tag, input int n);
    int t;
    t = 0;
    while (!(got_q.size() >= n && dbg_state == 3'd0) && t < 3000) begin
      @(negedge clk);
      t = t + 1;
    end
    if (t >= 3000) check_val({tag, "_timeout"}, 32'(t), 32'd0);
    tick(10);
  endtask

  task automatic push_ok(input logic [15:0] d);
    exp_q.push_back(8'h56);
    for (int i = 11; i >= 2; i--) exp_q.push_back(d[i] ? 8'h31 : 8'h30);
    exp_q.push_back(8'h0A);
  endtask

  // Compares the received bytes against the expected queue, then empties both.
  task automatic compare_reply(input string tag);
    check_val({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check_val({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    rst = 1'b1;
    uart_rx = 8'h00;
    uart_data_ready = 1'b0;
    i2c_busy = 1'b0;
    i2c_data_ready = 1'b0;
    i2c_rx_data = 16'h0000;
    uart_tx_busy = 1'b0;
    tick(3);
    check_val("rst_tx", 32'(uart_tx), 32'h00);
    check_val("rst_txload", 32'(uart_tx_load), 32'd0);
    check_val("rst_i2cload", 32'(i2c_load), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    check_val("i2c_addr", 32'(i2c_addr), 32'h0D);
    check_val("i2c_rw", 32'(i2c_r_w), 32'd1);
    check_val("i2c_bytes", 32'(i2c_bytes), 32'd1);
    rst = 1'b0;
    tick(2);

    // Readback on an idle bus, with a hand-computed byte list.
    base = i2c_load_cnt;
    send_byte(8'h76);
    wait_i2c_load(n);
    check_val("i2c_load_latency", 32'(n), 32'd1);
    i2c_respond(3, 16'h0AA8);
    n = 0;
    while (!uart_tx_load && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("tx_first_latency", 32'(n), 32'd1);
    wait_reply("rb_0aa8", 12);
    exp_q = '{8'h56, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h30,
              8'h31, 8'h30, 8'h31, 8'h30, 8'h0A};
    compare_reply("rb_0aa8");
    check_val("rb_0aa8_i2c_loads", 32'(i2c_load_cnt - base), 32'd1);

    // Extreme codes: the discarded bits must not leak into the reply.
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(2, 16'hFFFF);
    wait_reply("rb_ffff", 12);
    push_ok(16'hFFFF);
    compare_reply("rb_ffff");
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(2, 16'h0003);
    wait_reply("rb_0003", 12);
    exp_q = '{8'h56, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
              8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
    compare_reply("rb_0003");

    // Timeout: the I2C read never completes.
    send_byte(8'h76);
    wait_i2c_load(n);
    n = 0;
    while (!uart_tx_load && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("to_latency", 32'(n), 32'd17);
    wait_reply("to_err", 2);
    exp_q = '{8'h45, 8'h0A};
    compare_reply("to_err");

    // Data arrives on the final count cycle, so the reply must be OK.
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(15, 16'h0554);
    wait_reply("to_edge", 12);
    push_ok(16'h0554);
    compare_reply("to_edge");

    // I2C master stays busy for 50 cycles.
    base = i2c_load_cnt;
    i2c_busy = 1'b1;
    send_byte(8'h76);
    tick(50);
    check_val("i2cbusy_no_load", 32'(i2c_load_cnt - base), 32'd0);
    i2c_busy = 1'b0;
    wait_i2c_load(n);
    check_val("i2cbusy_load_seen", 32'(n >= 0), 32'd1);
    i2c_respond(1, 16'h0F0C);
    wait_reply("i2cbusy", 12);
    push_ok(16'h0F0C);
    compare_reply("i2cbusy");

    // UART transmitter stays busy for 20 cycles after each load.
    busy_len = 20;
    busy_viol = 0;
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(2, 16'h0554);
    wait_reply("txbusy", 12);
    push_ok(16'h0554);
    compare_reply("txbusy");
    check_val("txbusy_viol", 32'(busy_viol), 32'd0);
    busy_len = 1;

    // Ignored input: wrong bytes, a "v" mid-reply, and a "v" in TX_DONE.
    base = i2c_load_cnt;
    send_byte(8'h56);
    send_byte(8'h78);
    tick(10);
    check_val("ign_no_load", 32'(i2c_load_cnt - base), 32'd0);
    check_val("ign_no_bytes", 32'(got_q.size()), 32'd0);
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(2, 16'h0AA8);
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    send_byte(8'h76);
    n = 0;
    while (dbg_state != 3'd5 && n < 500) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("ign_reach_done", 32'(dbg_state), 32'd5);
    send_byte(8'h76);
    tick(20);
    check_val("ign_one_load", 32'(i2c_load_cnt - base), 32'd1);
    check_val("ign_idle", 32'(dbg_state), 32'd0);
    push_ok(16'h0AA8);
    compare_reply("ign");

    // Reset after the 5th UART_TxLoad.
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(2, 16'h0AA8);
    n = 0;
    while (got_q.size() < 5 && n < 500) begin
      @(negedge clk);
      n = n + 1;
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(30);
    check_val("rstmid_count", 32'(got_q.size()), 32'd5);
    check_val("rstmid_tx", 32'(uart_tx), 32'h00);
    check_val("rstmid_txload", 32'(uart_tx_load), 32'd0);
    check_val("rstmid_state", 32'(dbg_state), 32'd0);
    got_q.delete();
    send_byte(8'h76);
    wait_i2c_load(n);
    i2c_respond(2, 16'h0AA8);
    wait_reply("rstmid_fresh", 12);
    push_ok(16'h0AA8);
    compare_reply("rstmid_fresh");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dac_readback_fsm.md
Name: dac_readback_fsm

Overview:
Services the UART read-back command "v" for the DAC. On receipt it issues a 2-byte I2C read to the DAC and captures the 16-bit response. It then transmits the 10-bit DAC code back over UART as "V" followed by ten ASCII '0'/'1' characters, MSB first, and a terminating LF. It sits alongside the DAC write-command parser, on the same UART Rx byte stream and I2C master.

Parameters:
DAC_ADDR, 7'b0001101, 7-bit I2C address of the DAC
TIMEOUT_CYCLES, 1000000, clk cycles allowed from I2C_load to I2CDataReady before an error reply
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
UART_Rx  in  8  received UART byte, valid when UART_DataReady=1
UART_DataReady  in  1  one-cycle strobe per received byte
UART_Tx  out  8  byte to transmit
UART_TxLoad  out  1  one-cycle strobe loading UART_Tx into the UART transmitter
UART_TxBusy  in  1  UART transmitter busy
I2Caddr  out  7  I2C slave address, constant DAC_ADDR
I2Cr_w  out  1  constant 1 (read)
I2Cbytes  out  1  constant 1 (2-byte transfer)
I2C_load  out  1  one-cycle strobe starting the I2C read
I2CBusy  in  1  I2C master busy
I2CDataReady  in  1  one-cycle strobe: I2CRxData valid
I2CRxData  in  16  data read from the DAC

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; UART_TxLoad=0, I2C_load=0, UART_Tx=8'h00; captured data=0; bit counter=0; timeout counter=0. Reset mid-transfer abandons it immediately and sends no further bytes.
- States: IDLE, I2C_REQ, I2C_WAIT, TX_LOAD, TX_WAIT, TX_DONE.
- IDLE: on UART_DataReady && UART_Rx=="v" (8'h76), go to I2C_REQ. All other bytes are ignored. UART bytes arriving in any non-IDLE state are ignored; commands are not queued.
- I2C_REQ: wait while I2CBusy=1. In the first cycle with I2CBusy=0, assert I2C_load for exactly 1 cycle, clear the timeout counter, and go to I2C_WAIT.
- I2C_WAIT: increment the timeout counter each cycle.
  - On I2CDataReady, latch I2CRxData and set the reply sequence to OK.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, set the reply sequence to ERR.
  - Either case goes to TX_LOAD with the byte index at 0.
  - If I2CDataReady and the timeout coincide in the same cycle, the data wins (OK).
- Reply sequences:
  - OK is 12 bytes: index 0="V" (8'h56); indices 1..10 = ASCII '0'/'1' (8'h30/8'h31) of captured bits [11:2], bit 11 first; index 11=LF (8'h0A). Captured bits [15:12] and [1:0] are discarded.
  - ERR is 2 bytes: "E" (8'h45), LF.
- TX_LOAD: wait while UART_TxBusy=1. In the first cycle with UART_TxBusy=0, drive UART_Tx=byte[index], pulse UART_TxLoad for 1 cycle, and go to TX_WAIT.
- TX_WAIT: always spend ≥1 cycle here (covers the transmitter's 1-cycle busy latency). Then, once UART_TxBusy=0: if index is the last byte, go to TX_DONE; else increment index and go to TX_LOAD.
- TX_DONE: 1 cycle, then IDLE. A "v" arriving in the TX_DONE cycle is ignored.
- UART_Tx holds its last value between loads.
- At most one I2C_load per command; UART_TxLoad is never asserted while UART_TxBusy=1.
- Latency with no busy stalls: "v" strobe at cycle 0 gives I2C_load at cycle 2. The first UART_TxLoad occurs 2 cycles after I2CDataReady.

Test Plan:
- Readback, idle bus: "v", I2CRxData=16'h0AA8 (code 10'b1010101010) -> exactly one I2C_load, with I2Caddr=7'h0D, r_w=1, bytes=1; UART bytes 56,31,30,31,30,31,30,31,30,31,30,0A.
- Extremes: I2CRxData=16'hFFFF -> "V1111111111\n"; 16'h0003 -> "V0000000000\n" (low and high discard bits ignored).
- Timeout: TIMEOUT_CYCLES=16, never strobe I2CDataReady -> I2C_load, then 16 cycles later bytes 45,0A; I2CDataReady on the final count cycle -> OK reply, not ERR.
- Busy handshakes: hold I2CBusy=1 for 50 cycles -> I2C_load only after release. Hold UART_TxBusy high 20 cycles after each load -> 12 loads, none while busy, byte order intact.
- Ignored input: "V", "x", and a second "v" mid-reply -> no extra I2C_load and no extra bytes; IDLE afterwards.
- Reset mid-reply: assert rst after the 5th UART_TxLoad -> no further loads, outputs 0; a fresh "v" produces a complete 12-byte reply.
